// File: rtl/fifo_arb_defs.sv
// fifo_arb_defs: definitions shared by the drain arbiter, its handshake
// interface and the rotating picker.
//   arb_state_t : arbiter FSM encoding (IDLE=0, ACTIVE=1, STALL=2)
//   NUM_PORTS   : number of upstream FIFOs sharing the downstream FIFO
//   GRANT_WIDTH : width of a port index
package fifo_arb_defs;

    localparam int NUM_PORTS   = 4;
    localparam int GRANT_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } arb_state_t;

    typedef logic [GRANT_WIDTH-1:0] grant_t;

endpackage

// File: rtl/fifo_drain_arbiter_if.sv
// fifo_drain_arbiter_if: FIFO-side signals of the drain arbiter.
//   up_empty/up_afull/up_data : buf_empty, almost_full, buf_out of upstream FIFO i
//   up_rd_en                  : rd_en to upstream FIFO i (one-hot or zero)
//   dn_afull/dn_full          : almost_full / buf_full of the downstream FIFO
//   dn_data/dn_wr_en          : buf_in / wr_en of the downstream FIFO
// master = arbiter side, slave = FIFO side.
interface fifo_drain_arbiter_if #(
    parameter int DATA_WIDTH = 4
);
    import fifo_arb_defs::*;

    logic [NUM_PORTS-1:0]            up_empty;
    logic [NUM_PORTS-1:0]            up_afull;
    logic [NUM_PORTS*DATA_WIDTH-1:0] up_data;
    logic [NUM_PORTS-1:0]            up_rd_en;
    logic                            dn_afull;
    logic                            dn_full;
    logic [DATA_WIDTH-1:0]           dn_data;
    logic                            dn_wr_en;

    modport master (
        input  up_empty, up_afull, up_data, dn_afull, dn_full,
        output up_rd_en, dn_data, dn_wr_en
    );

    modport slave (
        output up_empty, up_afull, up_data, dn_afull, dn_full,
        input  up_rd_en, dn_data, dn_wr_en
    );

endinterface

// File: rtl/fifo_drain_arbiter_rr_pick4.sv
// rr_pick4: combinational 4-way rotating first-one finder.
//   req   : request vector
//   start : index where the search begins; it wraps, so start-1 is tried last
//   found : some request bit is set
//   idx   : first requesting index at or after start
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic       found,
    output logic [1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = start;
        for (int unsigned k = 0; k < 4; k++) begin
            if (!found && req[start + 2'(k)]) begin
                found = 1'b1;
                idx   = start + 2'(k);
            end
        end
    end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: round-robin drain of four upstream fifo16 instances into
// one downstream fifo16, with almost-full priority and a burst limit.
//   clk, rst   : clock; asynchronous active-low reset
//   enable     : low stops new arbitration (the in-flight word is still written)
//   bus        : upstream flags/data/rd_en and downstream flags/data/wr_en
//   grant      : index of the FIFO currently holding the grant
//   state      : FSM state (IDLE=0, ACTIVE=1, STALL=2)
//   xfer_count : words written downstream since reset, wrapping
module fifo_drain_arbiter
    import fifo_arb_defs::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int BURST      = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    fifo_drain_arbiter_if.master   bus,
    output logic [GRANT_WIDTH-1:0] grant,
    output logic [1:0]             state,
    output logic [CNT_WIDTH-1:0]   xfer_count
);

    localparam logic [3:0] BURST_MAX = 4'(BURST);

    arb_state_t           st;
    grant_t               grant_q, sel_d, start, af_idx, ne_idx, next_grant;
    logic [3:0]           burst_cnt, burst_next;
    logic [NUM_PORTS-1:0] nonempty, grant_oh;
    logic                 af_found, ne_found, any_ne, dn_block;
    logic                 pop, other_afull, rotate, wr_q;

    assign nonempty = ~bus.up_empty;
    assign any_ne   = |nonempty;
    assign dn_block = bus.dn_afull | bus.dn_full;
    assign start    = grant_q + 2'd1;
    assign grant_oh = 4'b0001 << grant_q;

    // Pop decision uses the live flags, so a FIFO that just went empty is
    // never read again in the following cycle.
    assign pop = (st == ACTIVE) & ~bus.up_empty[grant_q] & ~dn_block;

    rr_pick4 u_pick_afull (
        .req   (bus.up_afull),
        .start (start),
        .found (af_found),
        .idx   (af_idx)
    );

    rr_pick4 u_pick_nonempty (
        .req   (nonempty),
        .start (start),
        .found (ne_found),
        .idx   (ne_idx)
    );

    // The search wraps back to the holder last, so "no other candidate"
    // leaves the grant unchanged while still restarting the burst.
    assign next_grant  = af_found ? af_idx : (ne_found ? ne_idx : grant_q);
    assign other_afull = (|(bus.up_afull & ~grant_oh)) & ~bus.up_afull[grant_q];
    assign burst_next  = burst_cnt + 4'(pop);
    assign rotate      = (burst_next >= BURST_MAX) | bus.up_empty[grant_q] | other_afull;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            grant_q   <= '1;
            burst_cnt <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (enable && any_ne) begin
                        st        <= ACTIVE;
                        grant_q   <= next_grant;
                        burst_cnt <= '0;
                    end
                end
                ACTIVE: begin
                    if (!enable || !any_ne) begin
                        st <= IDLE;
                    end else if (dn_block) begin
                        st <= STALL;
                    end else if (rotate) begin
                        grant_q   <= next_grant;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_next;
                    end
                end
                STALL: begin
                    if (!enable || !any_ne) begin
                        st <= IDLE;
                    end else if (!dn_block) begin
                        st        <= ACTIVE;
                        grant_q   <= next_grant;
                        burst_cnt <= '0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    // Output stage: the popped word appears on the upstream buf_out one
    // cycle after rd_en, so the source index is delayed alongside wr_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q       <= 1'b0;
            sel_d      <= '0;
            xfer_count <= '0;
        end else begin
            wr_q  <= pop;
            sel_d <= grant_q;
            if (wr_q) begin
                xfer_count <= xfer_count + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.up_rd_en = pop ? grant_oh : '0;
    assign bus.dn_wr_en = wr_q;
    assign bus.dn_data  = wr_q ? bus.up_data[int'(sel_d)*DATA_WIDTH +: DATA_WIDTH] : '0;

    assign grant = grant_q;
    assign state = st;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb_fifo_drain_arbiter: upstream FIFOs are modelled as circular buffers whose
// registered buf_out updates on rd_en; a cycle-level reference of the
// arbitration rules predicts rd_en/grant/state while a scoreboard predicts the
// downstream word stream and transfer count. Directed scenarios pin literal
// sequences, then a randomized phase runs against the same reference.
module tb_fifo_drain_arbiter;

    localparam int DW    = 4;
    localparam int BURST = 2;
    localparam int CW    = 8;
    localparam int DEPTH = 16;
    localparam int AF_TH = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    grant;
    logic [1:0]    state;
    logic [CW-1:0] xfer_count;

    fifo_drain_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    fifo_drain_arbiter #(
        .DATA_WIDTH (DW),
        .BURST      (BURST),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus),
        .grant      (grant),
        .state      (state),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // upstream FIFO environment
    logic [DW-1:0] mem [4][DEPTH];
    int            head [4];
    int            fill [4];
    logic [DW-1:0] buf_out [4];
    int            pops [4];

    // reference model state (current and next)
    int m_state, m_grant, m_burst, m_wr, m_word, m_xfer;
    int n_state, n_grant, n_burst, n_wr, n_word, n_xfer;
    logic [3:0] rd_seen;
    int cyc;
    int wlog [$];
    int wcyc [$];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_flags();
        for (int i = 0; i < 4; i++) begin
            bus.up_empty[i]          = (fill[i] == 0);
            bus.up_afull[i]          = (fill[i] >= AF_TH);
            bus.up_data[i*DW +: DW]  = buf_out[i];
        end
    endtask

    task automatic push(int i, int v);
        if (fill[i] < DEPTH) begin
            mem[i][(head[i] + fill[i]) % DEPTH] = DW'(v);
            fill[i]++;
        end
        drive_flags();
    endtask

    task automatic model_reset();
        m_state = 0; m_grant = 3; m_burst = 0; m_wr = 0; m_word = 0; m_xfer = 0;
    endtask

    // Next holder: almost-full requesters first, then non-empty, searching
    // from the port after g and wrapping; nobody else -> g keeps it.
    function automatic int pick(int g, logic [3:0] afv, logic [3:0] emp);
        int c;
        for (int k = 1; k <= 4; k++) begin
            c = (g + k) % 4;
            if (afv[c]) return c;
        end
        for (int k = 1; k <= 4; k++) begin
            c = (g + k) % 4;
            if (!emp[c]) return c;
        end
        return g;
    endfunction

    task automatic check_phase();
        logic [3:0] emp, af, exp_rd;
        logic       blk, any, pop, hot_other;
        int         b;
        emp = bus.up_empty;
        af  = bus.up_afull;
        blk = bus.dn_afull | bus.dn_full;
        any = (emp != 4'hF);
        cyc++;
        if (!rst) begin
            chk("rst_rd_en", int'(bus.up_rd_en), 0);
            chk("rst_wr_en", int'(bus.dn_wr_en), 0);
            chk("rst_data", int'(bus.dn_data), 0);
            chk("rst_grant", int'(grant), 3);
            chk("rst_state", int'(state), 0);
            chk("rst_xfer", int'(xfer_count), 0);
            n_state = 0; n_grant = 3; n_burst = 0; n_wr = 0; n_word = 0; n_xfer = 0;
            rd_seen = '0;
            return;
        end
        pop    = (m_state == 1) && !emp[m_grant] && !blk;
        exp_rd = pop ? 4'(1 << m_grant) : 4'b0000;
        chk("up_rd_en", int'(bus.up_rd_en), int'(exp_rd));
        chk("grant", int'(grant), m_grant);
        chk("state", int'(state), m_state);
        chk("dn_wr_en", int'(bus.dn_wr_en), m_wr);
        chk("dn_data", int'(bus.dn_data), (m_wr != 0) ? m_word : 0);
        chk("xfer_count", int'(xfer_count), m_xfer);
        rd_seen = bus.up_rd_en;
        if (bus.dn_wr_en) begin
            wlog.push_back(int'(bus.dn_data));
            wcyc.push_back(cyc);
        end

        n_wr    = pop ? 1 : 0;
        n_word  = pop ? int'(mem[m_grant][head[m_grant]]) : 0;
        n_xfer  = (m_xfer + m_wr) % (1 << CW);
        n_state = m_state;
        n_grant = m_grant;
        n_burst = m_burst;
        hot_other = 1'b0;
        for (int k = 0; k < 4; k++) if (k != m_grant && af[k]) hot_other = 1'b1;
        case (m_state)
            0: if (enable && any) begin
                   n_state = 1; n_grant = pick(m_grant, af, emp); n_burst = 0;
               end
            1: if (!enable || !any) n_state = 0;
               else if (blk) n_state = 2;
               else begin
                   b = m_burst + (pop ? 1 : 0);
                   if (b >= BURST || emp[m_grant] || (hot_other && !af[m_grant])) begin
                       n_grant = pick(m_grant, af, emp); n_burst = 0;
                   end else begin
                       n_burst = b;
                   end
               end
            default: if (!enable || !any) n_state = 0;
               else if (!blk) begin
                   n_state = 1; n_grant = pick(m_grant, af, emp); n_burst = 0;
               end
        endcase
    endtask

    task automatic commit_phase();
        for (int i = 0; i < 4; i++) begin
            if (rd_seen[i] && fill[i] > 0) begin
                buf_out[i] = mem[i][head[i]];
                head[i]    = (head[i] + 1) % DEPTH;
                fill[i]--;
                pops[i]++;
            end
        end
        m_state = n_state; m_grant = n_grant; m_burst = n_burst;
        m_wr = n_wr; m_word = n_word; m_xfer = n_xfer;
        drive_flags();
    endtask

    task automatic step();
        @(negedge clk);
        check_phase();
        @(posedge clk);
        #1;
        commit_phase();
    endtask

    task automatic run_until_idle(string tag, int maxc);
        int n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < maxc) begin
            step();
            n++;
            done = (m_state == 0) && (m_wr == 0) &&
                   (fill[0] == 0) && (fill[1] == 0) && (fill[2] == 0) && (fill[3] == 0);
        end
        chk({tag, "_idle_reached"}, int'(done), 1);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        step();
        rst = 1'b1;
        wlog.delete();
        wcyc.delete();
    endtask

    task automatic chk_log(string tag, int exp []);
        chk({tag, "_count"}, wlog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wlog.size(); i++) begin
            chk($sformatf("%s_word%0d", tag, i), wlog[i], exp[i]);
        end
    endtask

    initial begin
        int p1;
        int exp_rr [];
        int exp_single [];
        int exp_pri [];
        int exp_bp [];
        int exp_one [];
        for (int i = 0; i < 4; i++) begin
            head[i] = 0; fill[i] = 0; buf_out[i] = '0; pops[i] = 0;
        end
        bus.dn_afull = 1'b0;
        bus.dn_full  = 1'b0;
        drive_flags();
        model_reset();
        cyc = 0;

        // reset state
        step();
        step();
        rst = 1'b1;
        step();

        // single source: FIFO 2 holds 3,7,9
        wlog.delete(); wcyc.delete();
        push(2, 3); push(2, 7); push(2, 9);
        enable = 1'b1;
        run_until_idle("single", 30);
        exp_single = '{3, 7, 9};
        chk_log("single", exp_single);
        if (wcyc.size() == 3) chk("single_back_to_back", wcyc[2] - wcyc[0], 2);
        chk("single_grant", int'(grant), 2);
        chk("single_xfer", int'(xfer_count), 3);
        chk("single_state", int'(state), 0);

        // round robin with BURST=2
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int n = 0; n < 4; n++) push(i, 4*i + n);
        run_until_idle("rr", 60);
        exp_rr = '{0, 1, 4, 5, 8, 9, 12, 13, 2, 3, 6, 7, 10, 11, 14, 15};
        chk_log("rr", exp_rr);
        if (wcyc.size() == 16) chk("rr_no_gaps", wcyc[15] - wcyc[0], 15);
        chk("rr_xfer", int'(xfer_count), 16);

        // almost-full priority preempts a burst in progress
        do_reset();
        for (int n = 1; n <= 4; n++) push(0, n);
        step();
        for (int n = 10; n <= 15; n++) push(3, n);
        @(negedge clk);
        chk("pri_first_pop", int'(bus.up_rd_en), 1);
        check_phase();
        @(posedge clk); #1; commit_phase();
        @(negedge clk);
        chk("pri_grant", int'(grant), 3);
        chk("pri_pop3", int'(bus.up_rd_en), 8);
        check_phase();
        @(posedge clk); #1; commit_phase();
        run_until_idle("pri", 60);
        exp_pri = '{1, 10, 11, 2, 3, 12, 13, 4, 14, 15};
        chk_log("pri", exp_pri);

        // downstream backpressure
        do_reset();
        for (int n = 1; n <= 6; n++) push(1, n);
        step(); step(); step();
        bus.dn_afull = 1'b1;
        @(negedge clk);
        chk("bp_no_pop", int'(bus.up_rd_en), 0);
        chk("bp_trailing_wr", int'(bus.dn_wr_en), 1);
        chk("bp_trailing_data", int'(bus.dn_data), 2);
        check_phase();
        @(posedge clk); #1; commit_phase();
        @(negedge clk);
        chk("bp_state_stall", int'(state), 2);
        chk("bp_wr_stops", int'(bus.dn_wr_en), 0);
        check_phase();
        @(posedge clk); #1; commit_phase();
        step();
        bus.dn_afull = 1'b0;
        run_until_idle("bp", 40);
        exp_bp = '{1, 2, 3, 4, 5, 6};
        chk_log("bp", exp_bp);

        // one-entry FIFO
        wlog.delete(); wcyc.delete();
        p1 = pops[1];
        push(1, 5);
        run_until_idle("one", 20);
        exp_one = '{5};
        chk_log("one", exp_one);
        chk("one_pop_count", pops[1] - p1, 1);

        // asynchronous reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int n = 0; n < 3; n++) push(i, 3*i + n);
        step(); step(); step();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_rd_en", int'(bus.up_rd_en), 0);
        chk("arst_wr_en", int'(bus.dn_wr_en), 0);
        chk("arst_data", int'(bus.dn_data), 0);
        chk("arst_grant", int'(grant), 3);
        chk("arst_state", int'(state), 0);
        chk("arst_xfer", int'(xfer_count), 0);
        model_reset();
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("arst_restart_grant", int'(grant), 0);
        check_phase();
        @(posedge clk); #1; commit_phase();
        run_until_idle("arst", 60);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int i;
            if ($urandom_range(0, 2) == 0) begin
                i = int'($urandom_range(0, 3));
                push(i, int'($urandom_range(0, 15)));
            end
            enable       = ($urandom_range(0, 19) != 0);
            bus.dn_afull = ($urandom_range(0, 4) == 0);
            bus.dn_full  = bus.dn_afull && ($urandom_range(0, 2) == 0);
            step();
        end
        enable = 1'b1;
        bus.dn_afull = 1'b0;
        bus.dn_full  = 1'b0;
        run_until_idle("rand", 200);
        chk("rand_drained", fill[0] + fill[1] + fill[2] + fill[3], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
